// File: rtl/sample_word_packer_if.sv
// Sample-in / packed-word-out stream bundle for sample_word_packer.
// master is the packer side, slave is the upstream/downstream side.
interface sample_word_packer_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
);
    logic [WIDTH-1:0]       s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH*LANES-1:0] m_data;
    logic [LANES-1:0]       m_keep;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_keep, m_valid, m_last
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_keep, m_valid, m_last
    );
endinterface

// File: rtl/sample_word_packer.sv
// Packs LANES samples per output word with packet framing and flush control.
// Define PACKER_SEQ_CHECK_EN to build the sample sequence checker.
module sample_word_packer #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 4,
    parameter int PKT_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    sample_word_packer_if.master bus,
    output logic [31:0]          pkt_cnt,
    output logic                 busy,
    output logic                 seq_err,
    output logic [15:0]          err_cnt
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [PW-1:0] LAST_WORD = PW'(PKT_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                 state, state_nx;
    logic [LW-1:0]          lane_cnt, lane_cnt_nx;
    logic [PW-1:0]          word_in_pkt, word_in_pkt_nx;
    logic [WIDTH*LANES-1:0] fill, fill_nx;
    logic [WIDTH*LANES-1:0] data_nx, out_data;
    logic [LANES-1:0]       keep_nx, out_keep;
    logic                   last_nx, out_last, out_valid;
    logic                   load, accept, slot_free;

    assign slot_free   = !out_valid || bus.m_ready;
    assign bus.s_ready = (state == RUN) && ((lane_cnt != LAST_LANE) || slot_free);
    assign accept      = bus.s_valid && bus.s_ready;

    assign bus.m_data  = out_data;
    assign bus.m_keep  = out_keep;
    assign bus.m_valid = out_valid;
    assign bus.m_last  = out_last;
    assign busy        = (state != IDLE) || out_valid;

    always_comb begin
        state_nx       = state;
        lane_cnt_nx    = lane_cnt;
        word_in_pkt_nx = word_in_pkt;
        fill_nx        = fill;
        data_nx        = '0;
        keep_nx        = '0;
        last_nx        = 1'b0;
        load           = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx       = RUN;
                    lane_cnt_nx    = '0;
                    word_in_pkt_nx = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    fill_nx[int'(lane_cnt)*WIDTH +: WIDTH] = bus.s_data;
                    if (lane_cnt == LAST_LANE) begin
                        load           = 1'b1;
                        data_nx        = fill_nx;
                        keep_nx        = '1;
                        last_nx        = (word_in_pkt == LAST_WORD);
                        lane_cnt_nx    = '0;
                        word_in_pkt_nx = last_nx ? '0 : word_in_pkt + 1'b1;
                    end else begin
                        lane_cnt_nx = lane_cnt + 1'b1;
                    end
                end
                if (flush || !enable) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    // Partial word: stale lanes from earlier words are masked off
                    if (lane_cnt != '0) begin
                        load    = 1'b1;
                        last_nx = 1'b1;
                        for (int l = 0; l < LANES; l++) begin
                            keep_nx[l] = (l < int'(lane_cnt));
                            if (keep_nx[l]) begin
                                data_nx[l*WIDTH +: WIDTH] = fill[l*WIDTH +: WIDTH];
                            end
                        end
                    end else if (word_in_pkt != '0) begin
                        load    = 1'b1;
                        last_nx = 1'b1;
                    end
                    lane_cnt_nx    = '0;
                    word_in_pkt_nx = '0;
                    state_nx       = enable ? RUN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lane_cnt    <= '0;
            word_in_pkt <= '0;
            fill        <= '0;
            out_data    <= '0;
            out_keep    <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            state       <= state_nx;
            lane_cnt    <= lane_cnt_nx;
            word_in_pkt <= word_in_pkt_nx;
            fill        <= fill_nx;
            if (out_valid && bus.m_ready && out_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (load) begin
                out_data  <= data_nx;
                out_keep  <= keep_nx;
                out_last  <= last_nx;
                out_valid <= 1'b1;
            end else if (bus.m_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PACKER_SEQ_CHECK_EN
    logic [WIDTH-1:0] prev;
    logic             armed;
    logic             step_ok;

    // Neighbours differ by one without wrapping; zero marks an emulator restart
    assign step_ok = (bus.s_data == '0)
        || ({1'b0, bus.s_data} == {1'b0, prev} + 1'b1)
        || ({1'b0, prev} == {1'b0, bus.s_data} + 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            armed   <= 1'b0;
            seq_err <= 1'b0;
            err_cnt <= '0;
        end else if ((state == IDLE) && enable) begin
            armed   <= 1'b0;
            seq_err <= 1'b0;
        end else if (accept) begin
            prev  <= bus.s_data;
            armed <= 1'b1;
            if (armed && !step_ok) begin
                seq_err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign seq_err = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_sample_word_packer.sv
// Self-checking bench for sample_word_packer: directed scenarios plus a
// randomized run against a queue-based packing model.
module tb_sample_word_packer;
    localparam int W   = 16;
    localparam int L   = 4;
    localparam int PKT = 3;
    localparam int DW  = W * L;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [L-1:0]  k;
        logic          l;
    } word_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic        flush  = 1'b0;
    logic [31:0] pkt_cnt;
    logic        busy;
    logic        seq_err;
    logic [15:0] err_cnt;
    int          checks = 0;
    int          errors = 0;

    sample_word_packer_if #(.WIDTH(W), .LANES(L)) bus ();

    sample_word_packer #(
        .WIDTH(W), .LANES(L), .PKT_WORDS(PKT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .bus(bus), .pkt_cnt(pkt_cnt), .busy(busy),
        .seq_err(seq_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        bus.s_data = d;
        bus.s_valid = 1'b1;
        #1;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data %h s_ready %b want 1", d, bus.s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_valid, bus.m_keep, bus.m_last, bus.s_ready, busy} !== '0) begin
            errors++;
            $display("FAIL reset_flags got v%b k%h l%b r%b b%b want 0",
                     bus.m_valid, bus.m_keep, bus.m_last, bus.s_ready, busy);
        end
        checks++;
        if (bus.m_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", bus.m_data);
        end
        checks++;
        if ({pkt_cnt, err_cnt, seq_err} !== '0) begin
            errors++;
            $display("FAIL reset_cnt got p%0d e%0d s%b want 0", pkt_cnt, err_cnt, seq_err);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got %b want 0", bus.s_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_ready got %b want 1", bus.s_ready);
        end
        send(16'd0);
        send(16'd1);
        send(16'd2);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got %b want 0", bus.m_valid);
        end
        send(16'd3);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h0003_0002_0001_0000
            || bus.m_keep !== 4'hF || bus.m_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_word got v%b %h k%h l%b want v1 0003000200010000 kf l0",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.m_last);
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got %b want 0", bus.m_valid);
        end
    endtask

    task automatic test_packet();
        do_reset();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4 * PKT; i++) begin
            send(W'(i));
            if (i == 7) begin
                checks++;
                if (bus.m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL pkt_mid_last got %b want 0", bus.m_last);
                end
            end
        end
        checks++;
        if (bus.m_data !== 64'h000B_000A_0009_0008 || bus.m_last !== 1'b1
            || pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL pkt_last got %h l%b p%0d want 000b000a00090008 l1 p0",
                     bus.m_data, bus.m_last, pkt_cnt);
        end
        @(negedge clk);
        checks++;
        if (pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL pkt_cnt got %0d want 1", pkt_cnt);
        end
        for (int i = 12; i < 16; i++) send(W'(i));
        checks++;
        if (bus.m_last !== 1'b0 || bus.m_data !== 64'h000F_000E_000D_000C) begin
            errors++;
            $display("FAIL pkt_wrap got %h l%b want 000f000e000d000c l0",
                     bus.m_data, bus.m_last);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.m_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) send(W'(i));
        bus.s_data = 16'd7;
        bus.s_valid = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready got %b want 0", bus.s_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h0003_0002_0001_0000
            || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v%b %h r%b want v1 0003000200010000 r0",
                     bus.m_valid, bus.m_data, bus.s_ready);
        end
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got %b want 1", bus.s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h0007_0006_0005_0004) begin
            errors++;
            $display("FAIL bp_second got v%b %h want v1 0007000600050004",
                     bus.m_valid, bus.m_data);
        end
    endtask

    task automatic test_flush();
        bit seen;
        do_reset();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        send(16'd10);
        send(16'd11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h0000_0000_000B_000A
            || bus.m_keep !== 4'h3 || bus.m_last !== 1'b1 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_partial got v%b %h k%h l%b r%b want v1 00000000000b000a k3 l1 r1",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, bus.s_ready);
        end
        for (int i = 0; i < 4; i++) send(W'(20 + i));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== '0
            || bus.m_keep !== 4'h0 || bus.m_last !== 1'b1) begin
            errors++;
            $display("FAIL flush_term got v%b %h k%h l%b want v1 0 k0 l1",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.m_last);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || pkt_cnt !== 32'd2) begin
            errors++;
            $display("FAIL flush_empty got word%b p%0d want word0 p2", seen, pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        bus.m_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) send(W'(i));
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.m_valid, bus.m_keep, bus.m_last, bus.s_ready, busy} !== '0
            || bus.m_data !== '0) begin
            errors++;
            $display("FAIL mid_reset got v%b %h k%h l%b r%b b%b want all 0",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, bus.s_ready, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.m_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_after got word%b p%0d want word0 p0", seen, pkt_cnt);
        end
    endtask

    task automatic test_idle_drain();
        do_reset();
        bus.m_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(W'(i));
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || busy !== 1'b1 || bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold got r%b b%b v%b want r0 b1 v1",
                     bus.s_ready, busy, bus.m_valid);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_keep !== 4'h0 || bus.m_last !== 1'b1
            || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_term got v%b k%h l%b b%b want v1 k0 l1 b1",
                     bus.m_valid, bus.m_keep, bus.m_last, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL drain_idle got v%b b%b p%0d want v0 b0 p1",
                     bus.m_valid, busy, pkt_cnt);
        end
    endtask

    task automatic test_seq_check();
        logic        exp_err;
        logic [15:0] exp_cnt;
`ifdef PACKER_SEQ_CHECK_EN
        exp_err = 1'b1;
        exp_cnt = 16'd1;
`else
        exp_err = 1'b0;
        exp_cnt = 16'd0;
`endif
        do_reset();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        send(16'd5);
        send(16'd6);
        send(16'd8);
        send(16'd0);
        send(16'd1);
        checks++;
        if (seq_err !== exp_err || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL seq_flag got s%b c%0d want s%b c%0d",
                     seq_err, err_cnt, exp_err, exp_cnt);
        end
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        send(16'd7);
        checks++;
        if (seq_err !== 1'b0 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL seq_rearm got s%b c%0d want s0 c%0d",
                     seq_err, err_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        localparam int N = 1500;
        word_t       exp_q[$];
        logic [W-1:0] cur[$];
        word_t       w;
        int          wip, pkts, errs_m, diff;
        logic [W-1:0] prev, base;
        bit          armed, acc;
        wip = 0;
        pkts = 0;
        errs_m = 0;
        prev = '0;
        base = '0;
        armed = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int cyc = 0; cyc < N + 30; cyc++) begin
            @(negedge clk);
            if (cyc < N) begin
                bus.s_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    5:       base = '0;
                    6:       base = base - 1'b1;
                    7:       base = W'($urandom);
                    default: base = base + 1'b1;
                endcase
                bus.s_data = base;
                bus.m_ready = ($urandom_range(0, 2) != 0);
                flush = ($urandom_range(0, 39) == 0);
            end else begin
                bus.s_valid = 1'b0;
                bus.m_ready = 1'b1;
                flush = (cyc == N);
            end
            #1;
            acc = bus.s_valid && bus.s_ready;
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got %h k%h l%b want no word",
                             bus.m_data, bus.m_keep, bus.m_last);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.m_data, bus.m_keep, bus.m_last} !== w) begin
                        errors++;
                        $display("FAIL rand_word got %h k%h l%b want %h k%h l%b",
                                 bus.m_data, bus.m_keep, bus.m_last, w.d, w.k, w.l);
                    end
                    if (w.l) pkts++;
                end
            end
            if (acc) begin
                diff = int'(bus.s_data) - int'(prev);
                if (armed && !(diff == 1 || diff == -1 || bus.s_data == '0)) errs_m++;
                prev = bus.s_data;
                armed = 1'b1;
                cur.push_back(bus.s_data);
                if (cur.size() == L) begin
                    w.d = '0;
                    for (int i = 0; i < L; i++) w.d[i*W +: W] = cur[i];
                    w.k = '1;
                    w.l = (wip == PKT - 1);
                    wip = (wip + 1) % PKT;
                    exp_q.push_back(w);
                    cur.delete();
                end
            end
            if (flush) begin
                if (cur.size() > 0) begin
                    w.d = '0;
                    w.k = '0;
                    for (int i = 0; i < cur.size(); i++) begin
                        w.d[i*W +: W] = cur[i];
                        w.k[i] = 1'b1;
                    end
                    w.l = 1'b1;
                    exp_q.push_back(w);
                end else if (wip > 0) begin
                    w.d = '0;
                    w.k = '0;
                    w.l = 1'b1;
                    exp_q.push_back(w);
                end
                cur.delete();
                wip = 0;
            end
        end
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || pkt_cnt !== 32'(pkts)) begin
            errors++;
            $display("FAIL rand_end got left%0d p%0d want left0 p%0d",
                     exp_q.size(), pkt_cnt, pkts);
        end
        checks++;
`ifdef PACKER_SEQ_CHECK_EN
        if (err_cnt !== 16'(errs_m) || seq_err !== (errs_m > 0)) begin
            errors++;
            $display("FAIL rand_seq got s%b c%0d want s%b c%0d",
                     seq_err, err_cnt, errs_m > 0, errs_m);
        end
`else
        if (err_cnt !== 16'd0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_seq got s%b c%0d want s0 c0", seq_err, err_cnt);
        end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_packet();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_idle_drain();
        test_seq_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
